// File: rtl/clock_ctrl_pkg.sv
// Shared types and helpers for the digital-clock sequencing controller.
// Optional blink divider is selected with CLOCK_CTRL_BLINK_EN (see tick_prescaler).
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_SET_HR  = 2'd2,
    ST_SET_MIN = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    F_SEC = 2'd0,
    F_MIN = 2'd1,
    F_HR  = 2'd2
  } field_sel_t;

  localparam int unsigned CLK_HZ_DEF  = 32'd100000000;
  localparam int unsigned TICK_HZ_DEF = 32'd1;

  // Counter width for a divider of n states, never narrower than one bit.
  function automatic int unsigned prescale_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Timebase prescaler producing a registered one-cycle tick while enabled.
// With CLOCK_CTRL_BLINK_EN defined it also hosts the CLK_HZ/4 blink divider.
module tick_prescaler
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
  parameter int unsigned TICK_HZ = TICK_HZ_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
`ifdef CLOCK_CTRL_BLINK_EN
  input  logic blink_en,
  output logic blink,
`endif
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = prescale_width(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 32'd1);

  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Prescaler next count; tick is registered so it lines up with the terminal count.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en) begin
      cnt_d  = (cnt_q == PRE_LAST) ? '0 : (cnt_q + PRE_W'(1));
      tick_d = (cnt_d == PRE_LAST);
    end else begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

`ifdef CLOCK_CTRL_BLINK_EN
  localparam int unsigned BLINK_DIV = CLK_HZ / 32'd4;
  localparam int unsigned BLK_W = prescale_width(BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 32'd1);

  logic [BLK_W-1:0] bcnt_q, bcnt_d;
  logic             blink_q, blink_d;

  // Blink divider: restarts lit whenever the enable drops.
  always_comb begin
    bcnt_d  = '0;
    blink_d = 1'b1;
    if (blink_en) begin
      if (bcnt_q == BLK_LAST) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + BLK_W'(1);
        blink_d = blink_q;
      end
    end else begin
      bcnt_d  = '0;
      blink_d = 1'b1;
    end
  end

  // Blink divider registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`endif

endmodule

// File: rtl/clock_ctrl_fsm.sv
// Run/stop/set-time controller driving the seconds, minutes and hours counters.
// Define CLOCK_CTRL_BLINK_EN to blink the display while setting the time.
module clock_ctrl_fsm
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
  parameter int unsigned TICK_HZ = TICK_HZ_DEF,
  parameter int unsigned BITS    = 8,
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MIN_MAX = 59,
  parameter int unsigned HR_MAX  = 23
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_btn,
  input  logic            mode_btn,
  input  logic            up_btn,
  input  logic            down_btn,
  input  logic [BITS-1:0] sec_value,
  input  logic [BITS-1:0] min_value,
  input  logic [BITS-1:0] hr_value,
  output logic            sec_start,
  output logic            min_start,
  output logic            hr_start,
  output logic            sec_fwd,
  output logic            min_fwd,
  output logic            hr_fwd,
  output logic            sec_clr,
  output logic            min_clr,
  output logic            hr_clr,
  output logic [1:0]      mode,
  output logic            tick,
  output logic            blink
);

  localparam logic [BITS-1:0] SEC_MAX_V = BITS'(SEC_MAX);
  localparam logic [BITS-1:0] MIN_MAX_V = BITS'(MIN_MAX);
  localparam logic [BITS-1:0] HR_MAX_V  = BITS'(HR_MAX);

  ctrl_state_t     state_q, state_d;
  logic [2:0]      start_q, start_d, fwd_q, fwd_d, clr_q, clr_d;
  logic            guard_s, run_s, mode_s, inc_s, dec_s;
  logic            sec_wrap_s, min_wrap_s, hr_wrap_s, tick_s, pre_en_s;
  logic [BITS-1:0] fval_s, fmax_s;
  logic            set_start_s, set_fwd_s, set_clr_s;

  // Counter values are stale while a strobe is being applied, so buttons are dropped then.
  assign guard_s = |{start_q, clr_q};
  assign run_s   = run_btn  & ~guard_s;
  assign mode_s  = mode_btn & ~guard_s;
  assign inc_s   = up_btn   & ~down_btn & ~guard_s;
  assign dec_s   = down_btn & ~up_btn   & ~guard_s;

  assign sec_wrap_s = (sec_value >= SEC_MAX_V);
  assign min_wrap_s = (min_value >= MIN_MAX_V);
  assign hr_wrap_s  = (hr_value  >= HR_MAX_V);

  assign fval_s      = (state_q == ST_SET_MIN) ? min_value : hr_value;
  assign fmax_s      = (state_q == ST_SET_MIN) ? MIN_MAX_V : HR_MAX_V;
  assign set_start_s = (inc_s & (fval_s < fmax_s)) | (dec_s & (fval_s != '0));
  assign set_fwd_s   = inc_s & (fval_s < fmax_s);
  assign set_clr_s   = inc_s & (fval_s >= fmax_s);

  // Mode transitions and next strobe values.
  always_comb begin
    state_d = state_q;
    start_d = 3'b000;
    fwd_d   = 3'b000;
    clr_d   = 3'b000;
    case (state_q)
      ST_STOPPED: begin
        if (mode_s)     state_d = ST_SET_HR;
        else if (run_s) state_d = ST_RUN;
        else            state_d = state_q;
      end
      ST_RUN: begin
        if (mode_s)     state_d = ST_SET_HR;
        else if (run_s) state_d = ST_STOPPED;
        else            state_d = state_q;
        start_d[F_SEC] = tick_s & ~sec_wrap_s;
        fwd_d[F_SEC]   = tick_s & ~sec_wrap_s;
        clr_d[F_SEC]   = tick_s & sec_wrap_s;
        start_d[F_MIN] = tick_s & sec_wrap_s & ~min_wrap_s;
        fwd_d[F_MIN]   = tick_s & sec_wrap_s & ~min_wrap_s;
        clr_d[F_MIN]   = tick_s & sec_wrap_s & min_wrap_s;
        start_d[F_HR]  = tick_s & sec_wrap_s & min_wrap_s & ~hr_wrap_s;
        fwd_d[F_HR]    = tick_s & sec_wrap_s & min_wrap_s & ~hr_wrap_s;
        clr_d[F_HR]    = tick_s & sec_wrap_s & min_wrap_s & hr_wrap_s;
      end
      ST_SET_HR: begin
        if (mode_s) begin
          state_d      = ST_SET_MIN;
          clr_d[F_SEC] = 1'b1;
        end else begin
          start_d[F_HR] = set_start_s;
          fwd_d[F_HR]   = set_fwd_s;
          clr_d[F_HR]   = set_clr_s;
        end
      end
      ST_SET_MIN: begin
        if (mode_s) begin
          state_d = ST_STOPPED;
        end else begin
          start_d[F_MIN] = set_start_s;
          fwd_d[F_MIN]   = set_fwd_s;
          clr_d[F_MIN]   = set_clr_s;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Mode and strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_STOPPED;
      start_q <= 3'b000;
      fwd_q   <= 3'b000;
      clr_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      fwd_q   <= fwd_d;
      clr_q   <= clr_d;
    end
  end

  // Prescaler runs only across cycles that stay in RUN, so it is zero on every entry.
  assign pre_en_s = (state_q == ST_RUN) && (state_d == ST_RUN);

`ifdef CLOCK_CTRL_BLINK_EN
  logic blink_en_s, blink_s;
  assign blink_en_s = ((state_q == ST_SET_HR) || (state_q == ST_SET_MIN)) && (state_d == state_q);
  assign blink      = blink_s;
`else
  assign blink = 1'b1;
`endif

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (pre_en_s),
`ifdef CLOCK_CTRL_BLINK_EN
    .blink_en (blink_en_s),
    .blink    (blink_s),
`endif
    .tick     (tick_s)
  );

  assign tick      = tick_s;
  assign mode      = state_q;
  assign sec_start = start_q[F_SEC];
  assign min_start = start_q[F_MIN];
  assign hr_start  = start_q[F_HR];
  assign sec_fwd   = fwd_q[F_SEC];
  assign min_fwd   = fwd_q[F_MIN];
  assign hr_fwd    = fwd_q[F_HR];
  assign sec_clr   = clr_q[F_SEC];
  assign min_clr   = clr_q[F_MIN];
  assign hr_clr    = clr_q[F_HR];

endmodule
